// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver that assembles NUM_BYTES bytes into one command frame
// Ports: clk, rst_n (async active-low); uart_rx serial line (idle high);
//        cmd_buf last complete frame (byte 0 = first on the wire); cmd_valid 1-cycle new-frame pulse;
//        frame_err 1-cycle bad-stop pulse; byte_idx bytes accepted in the current frame.
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_BYTES    = 12,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         uart_rx,
    output logic [NUM_BYTES-1:0][7:0]    cmd_buf,
    output logic                         cmd_valid,
    output logic                         frame_err,
    output logic [$clog2(NUM_BYTES)-1:0] byte_idx
);
    localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CW = $clog2(TO + 1);
    localparam int IW = $clog2(NUM_BYTES);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] TO_END   = CW'(TO - 1);
    localparam logic [IW-1:0] LAST     = IW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t                      state;
    logic                        rx_m, rx_s, rx_d;
    logic [CW-1:0]               cnt;
    logic [2:0]                  bit_n;
    logic [7:0]                  shreg;
    logic [NUM_BYTES-1:0][7:0]   work_buf, work_nxt;

    always_comb begin
        work_nxt           = work_buf;
        work_nxt[byte_idx] = shreg;
    end

    // cnt times bits while receiving and doubles as the inter-byte idle timer in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_d      <= 1'b1;
            cnt       <= '0;
            bit_n     <= '0;
            shreg     <= '0;
            work_buf  <= '0;
            cmd_buf   <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            byte_idx  <= '0;
        end else begin
            rx_m      <= uart_rx;
            rx_s      <= rx_m;
            rx_d      <= rx_s;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end else if (byte_idx == '0 || cnt == TO_END) begin
                        cnt      <= '0;
                        byte_idx <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        bit_n <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        bit_n <= bit_n + 1'b1;
                        state <= (bit_n == 3'd7) ? STOP : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : BREAK;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            byte_idx  <= '0;
                        end else if (byte_idx == LAST) begin
                            work_buf  <= work_nxt;
                            cmd_buf   <= work_nxt;
                            cmd_valid <= 1'b1;
                            byte_idx  <= '0;
                        end else begin
                            work_buf <= work_nxt;
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: state <= rx_s ? IDLE : BREAK;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: randomized self-checking bench for uart_cmd_rx against a byte/frame-level model
module tb_uart_cmd_rx;
    localparam int CPB = 16;
    localparam int NB  = 12;
    localparam int TOB = 20;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  uart_rx = 1'b1;
    logic [NB-1:0][7:0]    cmd_buf;
    logic                  cmd_valid;
    logic                  frame_err;
    logic [$clog2(NB)-1:0] byte_idx;

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .cmd_buf(cmd_buf), .cmd_valid(cmd_valid), .frame_err(frame_err), .byte_idx(byte_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_total = 0;
    int errs_seen = 0;
    int err_exp = 0;
    logic [7:0]      part[$];
    logic [8*NB-1:0] exp_q[$];
    logic [8*NB-1:0] last_frame = '0;

    task automatic check(input string tag, input logic [8*NB-1:0] obs, input logic [8*NB-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmd_valid) begin
            logic [8*NB-1:0] f;
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_cmd_valid", 1, 0);
            end else begin
                f = exp_q.pop_front();
                check("frame_data", cmd_buf, f);
                last_frame = f;
            end
        end
        if (rst_n && frame_err) errs_seen++;
    end

    task automatic drive(input logic v);
        uart_rx = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good, input int gap);
        logic [8*NB-1:0] f;
        if (good) begin
            part.push_back(b);
            if (part.size() == NB) begin
                for (int i = 0; i < NB; i++) f[i*8 +: 8] = part[i];
                exp_q.push_back(f);
                exp_total++;
                part.delete();
            end
        end else begin
            part.delete();
            err_exp++;
        end
        drive(1'b0);
        for (int i = 0; i < 8; i++) drive(b[i]);
        drive(good);
        @(negedge clk);
        check("byte_idx", byte_idx, part.size());
        check("cmd_buf_hold", cmd_buf, last_frame);
        uart_rx = 1'b1;
        repeat (gap * CPB) @(posedge clk);
    endtask

    task automatic send_rand_frame(input int maxgap);
        for (int i = 0; i < NB; i++) send_byte(8'($urandom), 1'b1, int'($urandom_range(maxgap, 0)));
    endtask

    logic [7:0] t1_bytes [NB] = '{8'h30, 8'h24, 8'h00, 8'hB0, 8'h5E, 8'h00,
                                  8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00};

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_buf", cmd_buf, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_byte_idx", byte_idx, 0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);

        for (int i = 0; i < NB; i++) send_byte(t1_bytes[i], 1'b1, 1);
        repeat (CPB) @(posedge clk);
        check("t1_pulses", pulses, 1);
        check("t1_byte0", cmd_buf[0], 8'h30);
        check("t1_byte3", cmd_buf[3], 8'hB0);
        check("t1_byte10", cmd_buf[10], 8'h07);
        check("t1_byte_idx", byte_idx, 0);

        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, int'($urandom_range(2, 0)));
        send_byte(8'($urandom), 1'b0, 2);
        check("t2_frame_err", errs_seen, 1);
        check("t2_no_valid", pulses, 1);
        send_rand_frame(2);
        check("t2_pulses", pulses, 2);

        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, 0);
        uart_rx = 1'b1;
        repeat (18 * CPB) @(posedge clk);
        @(negedge clk);
        check("t3_before_timeout", byte_idx, 5);
        repeat (3 * CPB) @(posedge clk);
        part.delete();
        @(negedge clk);
        check("t3_after_timeout", byte_idx, 0);
        send_rand_frame(1);
        check("t3_pulses", pulses, 3);

        uart_rx = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        check("t4_byte_idx", byte_idx, 0);
        check("t4_pulses", pulses, 3);
        check("t4_frame_err", errs_seen, 1);

        send_rand_frame(0);
        check("t5_mid_hold", cmd_buf, last_frame);
        send_rand_frame(0);
        check("t5_pulses", pulses, 5);

        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1, int'($urandom_range(1, 0)));
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        repeat (CPB / 2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_cmd_buf", cmd_buf, 0);
        check("t6_cmd_valid", cmd_valid, 0);
        check("t6_frame_err", frame_err, 0);
        check("t6_byte_idx", byte_idx, 0);
        uart_rx = 1'b1;
        part.delete();
        last_frame = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        send_rand_frame(3);
        repeat (CPB) @(posedge clk);

        check("total_pulses", pulses, exp_total);
        check("total_frame_err", errs_seen, err_exp);
        check("pending_frames", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
